// File: rtl/sniff_fifo_rd_arb.sv
`default_nettype none
// ============================================================================
// Module      : sniff_fifo_rd_arb
// Description : Shares the single pop port of the first-word-fall-through
//               sniff FIFO between the register path (one word per request)
//               and the streaming path (bulk reads in bounded bursts).
//               A pending register read takes the FIFO at the next burst
//               boundary. A register read that finds the FIFO empty waits a
//               bounded time and then returns an empty marker.
// Ports       : cwusb_clk / reset_i        clock, synchronous active-high reset
//               I_fifo_empty, I_fifo_data  FIFO flag and head word (FWFT)
//               O_fifo_read                FIFO pop strobe
//               I_reg_rd_req               register read request pulse
//               O_reg_busy/valid/data/empty register path result
//               I_strm_en, I_strm_ready    stream request and consumer ready
//               O_strm_valid, O_strm_data  stream output register
//               O_state                    FSM state (0 IDLE, 1 STRM, 2 REG_WAIT)
// Revision    : 1.0 - initial release
// ============================================================================
module sniff_fifo_rd_arb #(
    parameter int BURST   = 16,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        cwusb_clk,
    input  logic        reset_i,
    input  logic        I_fifo_empty,
    input  logic [17:0] I_fifo_data,
    output logic        O_fifo_read,
    input  logic        I_reg_rd_req,
    output logic        O_reg_busy,
    output logic        O_reg_valid,
    output logic [17:0] O_reg_data,
    output logic        O_reg_empty,
    input  logic        I_strm_en,
    input  logic        I_strm_ready,
    output logic        O_strm_valid,
    output logic [17:0] O_strm_data,
    output logic [1:0]  O_state
);

    localparam logic [1:0]       c_IDLE     = 2'd0;
    localparam logic [1:0]       c_STRM     = 2'd1;
    localparam logic [1:0]       c_REG_WAIT = 2'd2;
    localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] c_BURST    = CNT_W'(BURST);
    localparam logic [CNT_W-1:0] c_TMR_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_burst;
    logic [CNT_W-1:0] w_burst_nxt;
    logic [CNT_W-1:0] r_tmr;
    logic [CNT_W-1:0] w_tmr_nxt;

    logic             r_reg_pend;
    logic             r_reg_valid;
    logic [17:0]      r_reg_data;
    logic             r_reg_empty;
    logic             r_strm_valid;
    logic [17:0]      r_strm_data;

    logic             w_room;
    logic             w_strm_go;
    logic             w_burst_stop;
    logic             w_pop_reg;
    logic             w_pop_strm;
    logic             w_reg_timeout;

    // The stream register can take a new word if it is empty or being drained.
    assign w_room       = ~r_strm_valid | I_strm_ready;
    assign w_strm_go    = I_strm_en & ~I_fifo_empty & w_room;
    // Burst boundary only matters when the register path is waiting.
    assign w_burst_stop = r_reg_pend & (r_burst >= c_BURST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge cwusb_clk) begin
        if (reset_i) begin
            r_state <= c_IDLE;
            r_burst <= '0;
            r_tmr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_burst <= w_burst_nxt;
            r_tmr   <= w_tmr_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic (counters default to zero outside their state)
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_burst_nxt = '0;
        w_tmr_nxt   = '0;
        case (r_state)
            c_IDLE: begin
                if (r_reg_pend) begin
                    if (I_fifo_empty) begin
                        w_state_nxt = c_REG_WAIT;
                    end
                end else if (w_strm_go) begin
                    w_state_nxt = c_STRM;
                    w_burst_nxt = c_ONE;
                end
            end
            c_STRM: begin
                if (w_strm_go && !w_burst_stop) begin
                    w_burst_nxt = (r_burst == c_CNT_MAX) ? r_burst : r_burst + c_ONE;
                end else begin
                    w_state_nxt = c_IDLE;
                end
            end
            c_REG_WAIT: begin
                if (!I_fifo_empty || (r_tmr == c_TMR_LAST)) begin
                    w_state_nxt = c_IDLE;
                end else begin
                    w_tmr_nxt = r_tmr + c_ONE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode: who pops this cycle. Gated by reset so an aborted
    // transfer never removes a word from the FIFO.
    // ------------------------------------------------------------------
    always_comb begin
        w_pop_reg     = 1'b0;
        w_pop_strm    = 1'b0;
        w_reg_timeout = 1'b0;
        if (!reset_i) begin
            case (r_state)
                c_IDLE: begin
                    if (r_reg_pend) begin
                        w_pop_reg = ~I_fifo_empty;
                    end else begin
                        w_pop_strm = w_strm_go;
                    end
                end
                c_STRM: begin
                    w_pop_strm = w_strm_go & ~w_burst_stop;
                end
                c_REG_WAIT: begin
                    // A word present on the last wait cycle is returned, not the marker.
                    w_pop_reg     = ~I_fifo_empty;
                    w_reg_timeout = I_fifo_empty & (r_tmr == c_TMR_LAST);
                end
                default: begin
                    w_pop_reg = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath: request tracking and the two output registers
    // ------------------------------------------------------------------
    always_ff @(posedge cwusb_clk) begin
        if (reset_i) begin
            r_reg_pend   <= 1'b0;
            r_reg_valid  <= 1'b0;
            r_reg_data   <= '0;
            r_reg_empty  <= 1'b0;
            r_strm_valid <= 1'b0;
            r_strm_data  <= '0;
        end else begin
            if (w_pop_reg || w_reg_timeout) begin
                r_reg_pend  <= 1'b0;
                r_reg_valid <= 1'b1;
                r_reg_empty <= w_reg_timeout;
                r_reg_data  <= w_pop_reg ? I_fifo_data : '0;
            end else begin
                r_reg_valid <= 1'b0;
                r_reg_empty <= 1'b0;
                // A request while one is already pending is dropped.
                if (I_reg_rd_req) begin
                    r_reg_pend <= 1'b1;
                end
            end

            if (w_pop_strm) begin
                r_strm_data  <= I_fifo_data;
                r_strm_valid <= 1'b1;
            end else if (I_strm_ready) begin
                r_strm_valid <= 1'b0;
            end
        end
    end

    assign O_fifo_read  = w_pop_reg | w_pop_strm;
    assign O_reg_busy   = r_reg_pend;
    assign O_reg_valid  = r_reg_valid;
    assign O_reg_data   = r_reg_data;
    assign O_reg_empty  = r_reg_empty;
    assign O_strm_valid = r_strm_valid;
    assign O_strm_data  = r_strm_data;
    assign O_state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_sniff_fifo_rd_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_sniff_fifo_rd_arb
// Description : Self-checking bench for sniff_fifo_rd_arb. A queue models the
//               FWFT FIFO; expected register results and stream words are
//               queued as stimulus is applied and compared as the DUT
//               delivers them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sniff_fifo_rd_arb;

    localparam int c_BURST   = 16;
    localparam int c_TIMEOUT = 255;

    logic        cwusb_clk = 1'b0;
    logic        reset_i;
    logic        I_fifo_empty;
    logic [17:0] I_fifo_data;
    logic        O_fifo_read;
    logic        I_reg_rd_req;
    logic        O_reg_busy;
    logic        O_reg_valid;
    logic [17:0] O_reg_data;
    logic        O_reg_empty;
    logic        I_strm_en;
    logic        I_strm_ready;
    logic        O_strm_valid;
    logic [17:0] O_strm_data;
    logic [1:0]  O_state;

    logic [17:0] fifo_q[$];
    logic [18:0] exp_reg[$];   // {empty flag, data}
    logic [17:0] exp_strm[$];
    logic        pop_seen = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    sniff_fifo_rd_arb #(
        .BURST   (c_BURST),
        .TIMEOUT (c_TIMEOUT),
        .CNT_W   (8)
    ) dut (
        .cwusb_clk    (cwusb_clk),
        .reset_i      (reset_i),
        .I_fifo_empty (I_fifo_empty),
        .I_fifo_data  (I_fifo_data),
        .O_fifo_read  (O_fifo_read),
        .I_reg_rd_req (I_reg_rd_req),
        .O_reg_busy   (O_reg_busy),
        .O_reg_valid  (O_reg_valid),
        .O_reg_data   (O_reg_data),
        .O_reg_empty  (O_reg_empty),
        .I_strm_en    (I_strm_en),
        .I_strm_ready (I_strm_ready),
        .O_strm_valid (O_strm_valid),
        .O_strm_data  (O_strm_data),
        .O_state      (O_state)
    );

    always #5 cwusb_clk = ~cwusb_clk;

    task automatic fifo_refresh();
        I_fifo_empty = (fifo_q.size() == 0);
        I_fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : 18'h0;
    endtask

    task automatic fifo_push(input logic [17:0] w);
        fifo_q.push_back(w);
        fifo_refresh();
    endtask

    task automatic step();
        @(posedge cwusb_clk);
        #1;
    endtask

    // Mid-cycle monitor: pop legality and scoreboard comparison of outputs.
    always @(negedge cwusb_clk) begin
        logic [18:0] er;
        logic [17:0] es;
        pop_seen = O_fifo_read;
        if (O_fifo_read === 1'b1) begin
            n_checks++;
            if (I_fifo_empty !== 1'b0) $display("FAIL pop_on_empty: fifo_empty=%b required 0", I_fifo_empty);
            else n_pass++;
        end
        if (O_reg_valid === 1'b1) begin
            n_checks++;
            if (exp_reg.size() == 0) begin
                $display("FAIL reg_unexpected: got empty=%b data=%h, none expected", O_reg_empty, O_reg_data);
            end else begin
                er = exp_reg.pop_front();
                if ({O_reg_empty, O_reg_data} !== er)
                    $display("FAIL reg_result: got empty=%b data=%h required empty=%b data=%h",
                             O_reg_empty, O_reg_data, er[18], er[17:0]);
                else n_pass++;
            end
        end
        if (O_strm_valid === 1'b1 && I_strm_ready === 1'b1) begin
            n_checks++;
            if (exp_strm.size() == 0) begin
                $display("FAIL strm_unexpected: got %h, none expected", O_strm_data);
            end else begin
                es = exp_strm.pop_front();
                if (O_strm_data !== es) $display("FAIL strm_word: got %h required %h", O_strm_data, es);
                else n_pass++;
            end
        end
    end

    // FIFO model: remove the head word after the edge that popped it.
    always @(posedge cwusb_clk) begin
        if (pop_seen) begin
            #1;
            if (fifo_q.size() != 0) void'(fifo_q.pop_front());
            fifo_refresh();
        end
    end

    task automatic test_reset();
        reset_i = 1'b1;
        repeat (2) step();
        @(negedge cwusb_clk);
        n_checks++;
        if ({O_fifo_read, O_reg_busy, O_reg_valid, O_reg_data, O_reg_empty,
             O_strm_valid, O_strm_data, O_state} !== 43'h0)
            $display("FAIL reset_outputs: got state=%0d valid=%b strm_valid=%b required all zero",
                     O_state, O_reg_valid, O_strm_valid);
        else n_pass++;
        step();
        reset_i = 1'b0;
    endtask

    task automatic test_reg_read();
        step();
        fifo_push(18'h1A5A5);
        exp_reg.push_back({1'b0, 18'h1A5A5});
        step();
        I_reg_rd_req = 1'b1;
        @(negedge cwusb_clk);
        n_checks++;
        if (O_fifo_read !== 1'b0) $display("FAIL t1_no_early_pop: got %b required 0", O_fifo_read);
        else n_pass++;
        step();
        I_reg_rd_req = 1'b0;
        @(negedge cwusb_clk);
        n_checks++;
        if ({O_fifo_read, O_reg_busy} !== 2'b11) $display("FAIL t1_pop_n1: got read/busy=%b required 11", {O_fifo_read, O_reg_busy});
        else n_pass++;
        step();
        @(negedge cwusb_clk);
        n_checks++;
        if ({O_reg_valid, O_reg_busy} !== 2'b10) $display("FAIL t1_valid_n2: got valid/busy=%b required 10", {O_reg_valid, O_reg_busy});
        else n_pass++;
    endtask

    task automatic test_timeout();
        int cyc;
        bit found;
        step();
        exp_reg.push_back({1'b1, 18'h0});
        I_reg_rd_req = 1'b1;
        step();
        I_reg_rd_req = 1'b0;
        cyc   = 1;
        found = 1'b0;
        while (!found && cyc < 400) begin
            @(negedge cwusb_clk);
            if (cyc == 3) begin
                n_checks++;
                if ({O_state, O_reg_busy} !== 3'b101) $display("FAIL t2_wait_state: got state=%0d busy=%b required 2/1", O_state, O_reg_busy);
                else n_pass++;
            end
            if (O_reg_valid === 1'b1) found = 1'b1;
            else begin
                cyc++;
                step();
            end
        end
        n_checks++;
        if (!found || cyc != c_TIMEOUT + 2) $display("FAIL t2_timeout_latency: got %0d cycles (found=%0d) required %0d", cyc, found, c_TIMEOUT + 2);
        else n_pass++;
    endtask

    task automatic test_late_word();
        step();
        exp_reg.push_back({1'b0, 18'h2BEEF});
        I_reg_rd_req = 1'b1;
        step();
        I_reg_rd_req = 1'b0;
        repeat (11) step();
        fifo_push(18'h2BEEF);
        @(negedge cwusb_clk);
        n_checks++;
        if ({O_fifo_read, O_state} !== 3'b110) $display("FAIL t2_late_pop: got read=%b state=%0d required 1/2", O_fifo_read, O_state);
        else n_pass++;
        step();
        @(negedge cwusb_clk);
        n_checks++;
        if ({O_reg_valid, O_reg_empty, O_state} !== 4'b1000) $display("FAIL t2_late_valid: got valid=%b empty=%b state=%0d required 1/0/0", O_reg_valid, O_reg_empty, O_state);
        else n_pass++;
    endtask

    task automatic test_burst_preempt();
        int cyc;
        step();
        for (int i = 0; i < 40; i++) begin
            fifo_push(18'(18'h100 + i));
            if (i == c_BURST) exp_reg.push_back({1'b0, 18'(18'h100 + i)});
            else exp_strm.push_back(18'(18'h100 + i));
        end
        I_strm_ready = 1'b1;
        I_strm_en    = 1'b1;
        step();
        step();
        I_reg_rd_req = 1'b1;
        @(negedge cwusb_clk);
        n_checks++;
        if ({O_fifo_read, O_state} !== 3'b101) $display("FAIL t3_third_pop: got read=%b state=%0d required 1/1", O_fifo_read, O_state);
        else n_pass++;
        step();
        I_reg_rd_req = 1'b0;
        cyc = 0;
        while ((exp_strm.size() != 0 || exp_reg.size() != 0) && cyc < 200) begin
            step();
            cyc++;
        end
        n_checks++;
        if (exp_strm.size() != 0 || exp_reg.size() != 0 || fifo_q.size() != 0)
            $display("FAIL t3_drain: got %0d strm/%0d reg/%0d fifo left required 0", exp_strm.size(), exp_reg.size(), fifo_q.size());
        else n_pass++;
        I_strm_en    = 1'b0;
        I_strm_ready = 1'b0;
    endtask

    task automatic test_ready_toggle();
        int cyc;
        step();
        for (int i = 0; i < 100; i++) begin
            fifo_push(18'(18'h20000 + i));
            exp_strm.push_back(18'(18'h20000 + i));
        end
        I_strm_en = 1'b1;
        cyc = 0;
        while (exp_strm.size() != 0 && cyc < 1000) begin
            I_strm_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            @(negedge cwusb_clk);
            if (O_strm_valid === 1'b1 && I_strm_ready === 1'b0) begin
                n_checks++;
                if (O_fifo_read !== 1'b0) $display("FAIL t4_pop_no_room: got read=%b required 0", O_fifo_read);
                else n_pass++;
            end
            step();
            cyc++;
        end
        n_checks++;
        if (exp_strm.size() != 0 || fifo_q.size() != 0) $display("FAIL t4_drain: got %0d words left required 0", exp_strm.size());
        else n_pass++;
        I_strm_en    = 1'b0;
        I_strm_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int nvalid;
        step();
        fifo_push(18'h3C3C3);
        fifo_push(18'h0F0F0);
        exp_reg.push_back({1'b0, 18'h3C3C3});
        I_reg_rd_req = 1'b1;
        step();
        step();
        I_reg_rd_req = 1'b0;
        nvalid = 0;
        repeat (10) begin
            @(negedge cwusb_clk);
            if (O_reg_valid === 1'b1) nvalid++;
            step();
        end
        n_checks++;
        if (nvalid != 1 || fifo_q.size() != 1 || O_reg_busy !== 1'b0)
            $display("FAIL t5_single_valid: got %0d valids, %0d fifo words, busy=%b required 1/1/0", nvalid, fifo_q.size(), O_reg_busy);
        else n_pass++;
        fifo_q.delete();
        fifo_refresh();
    endtask

    task automatic test_reset_abort();
        int nvalid;
        // Abort while waiting on an empty FIFO.
        step();
        I_reg_rd_req = 1'b1;
        step();
        I_reg_rd_req = 1'b0;
        repeat (4) step();
        @(negedge cwusb_clk);
        n_checks++;
        if (O_state !== 2'd2) $display("FAIL t6_in_wait: got state=%0d required 2", O_state);
        else n_pass++;
        step();
        reset_i = 1'b1;
        fifo_push(18'h15555);
        @(negedge cwusb_clk);
        n_checks++;
        if (O_fifo_read !== 1'b0) $display("FAIL t6_wait_pop_in_reset: got %b required 0", O_fifo_read);
        else n_pass++;
        step();
        reset_i = 1'b0;
        @(negedge cwusb_clk);
        n_checks++;
        if ({O_fifo_read, O_reg_busy, O_reg_valid, O_reg_data, O_reg_empty,
             O_strm_valid, O_strm_data, O_state} !== 43'h0)
            $display("FAIL t6_wait_abort: got state=%0d busy=%b valid=%b read=%b required all zero", O_state, O_reg_busy, O_reg_valid, O_fifo_read);
        else n_pass++;
        nvalid = 0;
        repeat (c_TIMEOUT + 10) begin
            step();
            @(negedge cwusb_clk);
            if (O_reg_valid === 1'b1) nvalid++;
        end
        n_checks++;
        if (nvalid != 0) $display("FAIL t6_no_late_valid: got %0d valids required 0", nvalid);
        else n_pass++;
        step();
        fifo_q.delete();
        fifo_refresh();

        // Abort in the middle of a stream burst.
        step();
        for (int i = 0; i < 10; i++) begin
            fifo_push(18'(18'h3A000 + i));
            exp_strm.push_back(18'(18'h3A000 + i));
        end
        I_strm_en    = 1'b1;
        I_strm_ready = 1'b1;
        repeat (3) step();
        @(negedge cwusb_clk);
        n_checks++;
        if (O_state !== 2'd1) $display("FAIL t6_in_strm: got state=%0d required 1", O_state);
        else n_pass++;
        step();
        reset_i = 1'b1;
        @(negedge cwusb_clk);
        n_checks++;
        if (O_fifo_read !== 1'b0) $display("FAIL t6_strm_pop_in_reset: got %b required 0", O_fifo_read);
        else n_pass++;
        step();
        reset_i      = 1'b0;
        I_strm_en    = 1'b0;
        I_strm_ready = 1'b0;
        @(negedge cwusb_clk);
        n_checks++;
        if ({O_fifo_read, O_reg_busy, O_reg_valid, O_reg_data, O_reg_empty,
             O_strm_valid, O_strm_data, O_state} !== 43'h0)
            $display("FAIL t6_strm_abort: got state=%0d strm_valid=%b read=%b required all zero", O_state, O_strm_valid, O_fifo_read);
        else n_pass++;
        step();
        exp_strm.delete();
        fifo_q.delete();
        fifo_refresh();
    endtask

    initial begin
        reset_i      = 1'b1;
        I_reg_rd_req = 1'b0;
        I_strm_en    = 1'b0;
        I_strm_ready = 1'b0;
        fifo_refresh();

        test_reset();
        test_reg_read();
        test_timeout();
        test_late_word();
        test_burst_preempt();
        test_ready_toggle();
        test_back_to_back();
        test_reset_abort();

        repeat (3) step();
        n_checks++;
        if (exp_reg.size() != 0 || exp_strm.size() != 0)
            $display("FAIL final_scoreboard: got %0d reg/%0d strm outstanding required 0", exp_reg.size(), exp_strm.size());
        else n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
